// File: rtl/lsu_if.sv
// Request, response and data-memory signals of the load/store unit.
// The execute stage and the memory model sit on the master side.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_func3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_func3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one request at a time, alignment/legality/range checks,
// byte-lane conversion to a single-cycle synchronous word memory.
module lsu #(
  parameter int unsigned MEM_WORDS = 40
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEM, LWAIT, RESP} state_t;

  state_t      state, state_n;
  logic        we_q;
  logic [2:0]  func3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        req_bad;
  logic [31:0] lane;
  logic [31:0] load_ext;
  logic [3:0]  store_be;
  logic        req_ready, resp_valid, mem_en, mem_we;
  logic [3:0]  mem_be;

  always_comb begin
    req_bad = 1'b0;
    case (bus.req_func3)
      3'b000, 3'b100: req_bad = 1'b0;
      3'b001, 3'b101: req_bad = bus.req_addr[0];
      3'b010:         req_bad = (bus.req_addr[1:0] != 2'b00);
      default:        req_bad = 1'b1;
    endcase
    if (bus.req_func3[2] && bus.req_we)
      req_bad = 1'b1;
    if (bus.req_addr[31:2] >= 30'(MEM_WORDS))
      req_bad = 1'b1;
  end

  always_comb begin
    store_be = 4'b1111;
    if (we_q) begin
      case (func3_q[1:0])
        2'b00:   store_be = 4'b0001 << addr_q[1:0];
        2'b01:   store_be = addr_q[1] ? 4'b1100 : 4'b0011;
        default: store_be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    lane     = data_q >> {addr_q[1:0], 3'b000};
    load_ext = data_q;
    case (func3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_ext = {24'h0, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_ext = {16'h0, lane[15:0]};
      default: load_ext = data_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Strobes are gated by rst so an in-flight MEM cycle is killed before the next edge.
  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          req_ready = 1'b1;
          if (bus.req_valid) state_n = req_bad ? RESP : MEM;
        end
        MEM: begin
          mem_en  = 1'b1;
          mem_we  = we_q;
          mem_be  = store_be;
          state_n = we_q ? RESP : LWAIT;
        end
        LWAIT: state_n = RESP;
        RESP: begin
          resp_valid = 1'b1;
          if (bus.resp_ready) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      func3_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        func3_q <= bus.req_func3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= req_bad;
      end
      if (state == LWAIT) data_q <= bus.mem_rdata;
    end
  end

  always_comb begin
    case (func3_q[1:0])
      2'b00:   bus.mem_wdata = {4{wdata_q[7:0]}};
      2'b01:   bus.mem_wdata = {2{wdata_q[15:0]}};
      default: bus.mem_wdata = wdata_q;
    endcase
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_err   = resp_valid & err_q;
  assign bus.resp_rdata = (resp_valid && !we_q && !err_q) ? load_ext : '0;
  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_be     = mem_be;
  assign bus.mem_addr   = addr_q[31:2];
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a 40-word byte-enabled memory model, a vector
// table for single transactions, and hand sequences for backpressure and reset.
module tb_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  lsu_if mif();

  lsu #(.MEM_WORDS(40)) dut (.clk(clk), .rst(rst), .bus(mif));

  always #5 clk = ~clk;

  logic [31:0] mem [40] = '{default: 32'h0};
  logic [31:0] rd_q = 32'h0;
  assign mif.mem_rdata = rd_q;

  always @(posedge clk) begin
    if (mif.mem_en && mif.mem_addr < 30'd40) begin
      if (mif.mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mif.mem_be[i]) mem[mif.mem_addr[5:0]][8*i +: 8] <= mif.mem_wdata[8*i +: 8];
      end else begin
        rd_q <= mem[mif.mem_addr[5:0]];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] mwdata;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t v(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                             input logic [3:0] be, input logic [31:0] mwdata);
    vec_t r;
    r.we = we; r.f3 = f3; r.addr = addr; r.wdata = wdata;
    r.rdata = rdata; r.err = err; r.be = be; r.mwdata = mwdata;
    return r;
  endfunction

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    mif.req_valid = 1'b1;
    mif.req_we    = we;
    mif.req_func3 = f3;
    mif.req_addr  = addr;
    mif.req_wdata = wdata;
  endtask

  // One transaction with resp_ready=1; checks latency, memory-port fields and response.
  task automatic run(input int idx, input vec_t t);
    int lat, mem_cnt, mem_cyc;
    logic [3:0]  be_c;
    logic [29:0] ad_c;
    logic [31:0] wd_c, rdata_c;
    logic        we_c, err_c;
    string s;
    lat = 0; mem_cnt = 0; mem_cyc = 0; be_c = '0; ad_c = '0; wd_c = '0; we_c = 1'b0;
    rdata_c = '0; err_c = 1'b0;
    @(negedge clk);
    s = $sformatf("v%0d", idx);
    chk({s, "_req_ready"}, {31'h0, mif.req_ready}, 32'd1);
    drive_req(t.we, t.f3, t.addr, t.wdata);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      mif.req_valid = 1'b0;
      if (mif.mem_en) begin
        mem_cnt++;
        mem_cyc = n; be_c = mif.mem_be; ad_c = mif.mem_addr; wd_c = mif.mem_wdata; we_c = mif.mem_we;
      end
      if (mif.resp_valid) begin
        lat = n; rdata_c = mif.resp_rdata; err_c = mif.resp_err;
        break;
      end
    end
    chk({s, "_latency"}, lat, t.err ? 1 : (t.we ? 2 : 3));
    chk({s, "_err"}, {31'h0, err_c}, {31'h0, t.err});
    chk({s, "_rdata"}, rdata_c, t.err ? 32'h0 : t.rdata);
    chk({s, "_mem_en_cycles"}, mem_cnt, t.err ? 0 : 1);
    if (!t.err) begin
      chk({s, "_mem_cycle"}, mem_cyc, 1);
      chk({s, "_mem_we"}, {31'h0, we_c}, {31'h0, t.we});
      chk({s, "_mem_addr"}, {2'b00, ad_c}, {2'b00, t.addr[31:2]});
      chk({s, "_mem_be"}, {28'h0, be_c}, {28'h0, t.be});
      if (t.we) chk({s, "_mem_wdata"}, wd_c, t.mwdata);
    end
  endtask

  logic [31:0] held;
  int          lat_bp;

  initial begin
    vecs[0]  = v(1, 3'b010, 32'h08, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'hDEADBEEF);
    vecs[1]  = v(0, 3'b010, 32'h08, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h0);
    vecs[2]  = v(1, 3'b010, 32'h08, 32'h80FF7F01, 32'h0,        0, 4'b1111, 32'h80FF7F01);
    vecs[3]  = v(0, 3'b000, 32'h0A, 32'h0,        32'hFFFFFFFF, 0, 4'b1111, 32'h0);
    vecs[4]  = v(0, 3'b100, 32'h0B, 32'h0,        32'h00000080, 0, 4'b1111, 32'h0);
    vecs[5]  = v(0, 3'b001, 32'h08, 32'h0,        32'h00007F01, 0, 4'b1111, 32'h0);
    vecs[6]  = v(0, 3'b101, 32'h0A, 32'h0,        32'h000080FF, 0, 4'b1111, 32'h0);
    vecs[7]  = v(0, 3'b001, 32'h0A, 32'h0,        32'hFFFF80FF, 0, 4'b1111, 32'h0);
    vecs[8]  = v(0, 3'b000, 32'h08, 32'h0,        32'h00000001, 0, 4'b1111, 32'h0);
    vecs[9]  = v(1, 3'b000, 32'h0D, 32'h123456AB, 32'h0,        0, 4'b0010, 32'hABABABAB);
    vecs[10] = v(1, 3'b001, 32'h0E, 32'h0000CAFE, 32'h0,        0, 4'b1100, 32'hCAFECAFE);
    vecs[11] = v(0, 3'b010, 32'h0C, 32'h0,        32'hCAFEAB00, 0, 4'b1111, 32'h0);
    vecs[12] = v(0, 3'b000, 32'h0D, 32'h0,        32'hFFFFFFAB, 0, 4'b1111, 32'h0);
    vecs[13] = v(0, 3'b101, 32'h0E, 32'h0,        32'h0000CAFE, 0, 4'b1111, 32'h0);
    vecs[14] = v(1, 3'b010, 32'h9C, 32'h11223344, 32'h0,        0, 4'b1111, 32'h11223344);
    vecs[15] = v(0, 3'b010, 32'h9C, 32'h0,        32'h11223344, 0, 4'b1111, 32'h0);
    vecs[16] = v(0, 3'b010, 32'h06, 32'h0,        32'h0,        1, 4'b0000, 32'h0);
    vecs[17] = v(0, 3'b001, 32'h03, 32'h0,        32'h0,        1, 4'b0000, 32'h0);
    vecs[18] = v(0, 3'b010, 32'hA0, 32'h0,        32'h0,        1, 4'b0000, 32'h0);
    vecs[19] = v(0, 3'b011, 32'h00, 32'h0,        32'h0,        1, 4'b0000, 32'h0);
    vecs[20] = v(1, 3'b100, 32'h00, 32'h0,        32'h0,        1, 4'b0000, 32'h0);
    vecs[21] = v(0, 3'b110, 32'h00, 32'h0,        32'h0,        1, 4'b0000, 32'h0);
    vecs[22] = v(1, 3'b010, 32'h0A, 32'hFFFFFFFF, 32'h0,        1, 4'b0000, 32'h0);
    vecs[23] = v(1, 3'b010, 32'hA0, 32'hFFFFFFFF, 32'h0,        1, 4'b0000, 32'h0);
    vecs[24] = v(0, 3'b010, 32'h08, 32'h0,        32'h80FF7F01, 0, 4'b1111, 32'h0);
    vecs[25] = v(1, 3'b000, 32'h0F, 32'h00000077, 32'h0,        0, 4'b1000, 32'h77777777);
    vecs[26] = v(0, 3'b010, 32'h0C, 32'h0,        32'h77FEAB00, 0, 4'b1111, 32'h0);
    vecs[27] = v(0, 3'b100, 32'h0C, 32'h0,        32'h00000000, 0, 4'b1111, 32'h0);

    mif.req_valid = 1'b0; mif.req_we = 1'b0; mif.req_func3 = '0;
    mif.req_addr = '0; mif.req_wdata = '0; mif.resp_ready = 1'b1;

    @(negedge clk);
    chk("reset_outputs",
        {mif.req_ready, mif.resp_valid, mif.resp_err, mif.mem_en, mif.mem_we, mif.mem_be,
         mif.mem_addr[23:0]} | mif.resp_rdata | mif.mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_reset", {31'h0, mif.req_ready}, 32'd1);

    for (int i = 0; i < 28; i++) run(i, vecs[i]);

    // Backpressure on a load response
    @(negedge clk);
    mif.resp_ready = 1'b0;
    drive_req(1'b0, 3'b010, 32'h0C, 32'h0);
    lat_bp = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      mif.req_valid = 1'b0;
      if (mif.resp_valid) begin lat_bp = n; break; end
    end
    chk("bp_latency", lat_bp, 3);
    held = mif.resp_rdata;
    chk("bp_rdata", held, 32'h77FEAB00);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive_req(1'b1, 3'b010, 32'h10, 32'h0BADF00D);
      chk("bp_valid_held", {31'h0, mif.resp_valid}, 32'd1);
      chk("bp_rdata_held", mif.resp_rdata, held);
      chk("bp_req_ready_low", {31'h0, mif.req_ready}, 32'd0);
      chk("bp_no_mem", {31'h0, mif.mem_en}, 32'd0);
    end
    mif.req_valid = 1'b0;
    mif.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_after", {30'h0, mif.req_ready, mif.resp_valid}, 32'd2);
    run(100, v(0, 3'b010, 32'h10, 32'h0, 32'h00000000, 0, 4'b1111, 32'h0));

    // Reset while a store is in its MEM cycle
    @(negedge clk);
    drive_req(1'b1, 3'b010, 32'h08, 32'h55555555);
    @(negedge clk);
    mif.req_valid = 1'b0;
    chk("rst_mid_mem_en_before", {31'h0, mif.mem_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs",
        {mif.req_ready, mif.resp_valid, mif.resp_err, mif.mem_en, mif.mem_we, mif.mem_be,
         mif.mem_addr[23:0]} | mif.resp_rdata | mif.mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_mid_ready", {31'h0, mif.req_ready}, 32'd1);
    chk("rst_mid_no_resp", {31'h0, mif.resp_valid}, 32'd0);
    run(101, v(0, 3'b010, 32'h08, 32'h0, 32'h80FF7F01, 0, 4'b1111, 32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
